pfifo: RTL

Parametrised successor to the UART byte FIFO: a synchronous first-word-fall-through FIFO with configurable width and depth. It adds full-depth occupancy, a run-time threshold flag, synchronous flush and sticky clearable error flags. It sits between the UART RX/TX engines and the Wishbone register file. It exports the same 16-bit status word layout so existing driver software reads it unchanged.

---
 rtl/pfifo.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/pfifo.sv
// pfifo: synchronous first-word-fall-through FIFO, 2^LGFLEN x BW, full-depth occupancy.
//
// Parameters
//   BW      data width (1..32)
//   LGFLEN  log2 of depth (2..9)
//   RXFIFO  1: status/threshold use fill count; 0: use free space
//
// Ports
//   i_clk, i_rst_n      clock, asynchronous active-low reset
//   i_clr               synchronous flush (errors are kept)
//   i_wr, i_data        write strobe and data
//   i_rd                pop strobe
//   o_data, o_empty_n   registered head word and its valid flag
//   o_full, o_fill      no free slot; words held (0..2^LGFLEN)
//   i_thresh, o_thresh  threshold compare on fill (RXFIFO=1) or free space (RXFIFO=0)
//   i_err_clr, o_err    sticky error flag and its clear
//   o_status            {LGFLEN[3:0], count[9:0], half, avail}
//
// Optional feature: define PFIFO_UNFL_EN to record reads from an empty FIFO as a sticky
// underflow error folded into o_err.
module pfifo #(
    parameter int unsigned BW     = 8,
    parameter int unsigned LGFLEN = 4,
    parameter bit          RXFIFO = 1'b0
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_clr,
    input  logic              i_wr,
    input  logic [BW-1:0]     i_data,
    output logic              o_full,
    input  logic              i_rd,
    output logic [BW-1:0]     o_data,
    output logic              o_empty_n,
    input  logic [LGFLEN:0]   i_thresh,
    output logic              o_thresh,
    output logic [LGFLEN:0]   o_fill,
    input  logic              i_err_clr,
    output logic              o_err,
    output logic [15:0]       o_status
);

    localparam int unsigned Depth = 1 << LGFLEN;

    typedef logic [LGFLEN:0]   ptr_t;
    typedef logic [LGFLEN-1:0] addr_t;

    localparam ptr_t DepthP = ptr_t'(Depth);
    localparam ptr_t HalfP  = ptr_t'(Depth / 2);

    logic [BW-1:0] mem_q [Depth];

    ptr_t          wptr_q, wptr_d;
    ptr_t          rptr_q, rptr_d;
    ptr_t          fill_q, fill_d;
    logic          full_q, full_d;
    logic          empty_n_q, empty_n_d;
    logic [BW-1:0] data_q, data_d;
    logic          ovfl_q, ovfl_d;

    logic  wr_acc, rd_acc;
    addr_t rd_next_addr;
    ptr_t  count;
    logic  avail;

    assign wr_acc       = i_wr && (!full_q || i_rd);
    assign rd_acc       = i_rd && empty_n_q;
    assign rd_next_addr = rptr_q[LGFLEN-1:0] + addr_t'(1);

    always_comb begin
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        fill_d    = fill_q;
        full_d    = full_q;
        empty_n_d = empty_n_q;
        data_d    = data_q;
        if (i_clr) begin
            wptr_d    = '0;
            rptr_d    = '0;
            fill_d    = '0;
            full_d    = 1'b0;
            empty_n_d = 1'b0;
        end else begin
            if (wr_acc) wptr_d = wptr_q + ptr_t'(1);
            if (rd_acc) rptr_d = rptr_q + ptr_t'(1);
            fill_d    = fill_q + ptr_t'(wr_acc) - ptr_t'(rd_acc);
            full_d    = (fill_d == DepthP);
            empty_n_d = (fill_d != '0);
            // Keep o_data equal to the head word after this edge.
            if (rd_acc) begin
                if (fill_q == ptr_t'(1)) begin
                    // Draining the last word: a same-cycle write becomes the new head.
                    if (wr_acc) data_d = i_data;
                end else begin
                    data_d = mem_q[rd_next_addr];
                end
            end else if (wr_acc && !empty_n_q) begin
                data_d = i_data;
            end
        end
    end

    // Overflow: write refused because full with no pop; set wins over clear.
    assign ovfl_d = (!i_clr && i_wr && full_q && !i_rd) || (ovfl_q && !i_err_clr);

    always_ff @(posedge i_clk) begin
        if (wr_acc && !i_clr) mem_q[wptr_q[LGFLEN-1:0]] <= i_data;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            fill_q    <= '0;
            full_q    <= 1'b0;
            empty_n_q <= 1'b0;
            data_q    <= '0;
            ovfl_q    <= 1'b0;
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            fill_q    <= fill_d;
            full_q    <= full_d;
            empty_n_q <= empty_n_d;
            data_q    <= data_d;
            ovfl_q    <= ovfl_d;
        end
    end

`ifdef PFIFO_UNFL_EN
    logic unfl_q, unfl_d;

    // A read on an empty FIFO with a same-cycle write is not an underflow.
    assign unfl_d = (!i_clr && i_rd && !empty_n_q && !i_wr) || (unfl_q && !i_err_clr);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) unfl_q <= 1'b0;
        else          unfl_q <= unfl_d;
    end

    assign o_err = ovfl_q | unfl_q;
`else
    assign o_err = ovfl_q;
`endif

    assign count = RXFIFO ? fill_q : (DepthP - fill_q);
    assign avail = RXFIFO ? empty_n_q : !full_q;

    assign o_full    = full_q;
    assign o_empty_n = empty_n_q;
    assign o_data    = data_q;
    assign o_fill    = fill_q;
    assign o_thresh  = (count >= i_thresh);
    assign o_status  = {4'(LGFLEN), 10'(count), (count >= HalfP), avail};

endmodule
